// File: rtl/cve2_sram_arbiter.sv
// Round-robin arbiter serving the core's fetch and data ports from one
// single-port synchronous SRAM with 1-cycle read latency.
// Ports: clk_i, rst_i (async, active-high); instr_* fetch req/gnt/rvalid
// bus; data_* load/store req/gnt/rvalid bus; mem_* SRAM access strobe,
// write, byte mask, word index, write data and read data (valid 1 cycle
// after mem_req_o). Grant is same-cycle, response exactly one cycle later,
// addresses outside [BaseAddr, BaseAddr+MemWords*4) answer with err.
// Optional: define CVE2_SRAM_ARBITER_STATS_EN to add saturating
// grant/conflict/error counters on stat_*_o outputs.
module cve2_sram_arbiter #(
    parameter int          MemWords = 4096,
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    localparam int         AW       = $clog2(MemWords)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    input  logic [31:0]   instr_addr_i,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,
`ifdef CVE2_SRAM_ARBITER_STATS_EN
    output logic [31:0]   stat_instr_gnt_o,
    output logic [31:0]   stat_data_gnt_o,
    output logic [31:0]   stat_conflict_o,
    output logic [31:0]   stat_err_o,
`endif
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    // Window size in bytes, one bit wider so MemWords*4 cannot wrap.
    localparam logic [32:0] Limit = 33'(MemWords) << 2;

    // r_ptr_data: data wins the next conflict (i.e. instr was granted last).
    logic        r_ptr_data;
    logic        r_rv_i;
    logic        r_rv_d;
    logic        r_err;
    logic        r_rd;

    logic        w_gnt_i;
    logic        w_gnt_d;
    logic        w_gnt;
    logic        w_inrange;
    logic [31:0] w_addr;
    logic [31:0] w_off;

    // Grants are masked during reset so all gnt outputs read 0.
    assign w_gnt_d = ~rst_i & data_req_i & (~instr_req_i | r_ptr_data);
    assign w_gnt_i = ~rst_i & instr_req_i & (~data_req_i | ~r_ptr_data);
    assign w_gnt   = w_gnt_i | w_gnt_d;

    // Unsigned wrap makes addresses below BaseAddr land out of range too.
    assign w_addr    = w_gnt_d ? data_addr_i : instr_addr_i;
    assign w_off     = w_addr - BaseAddr;
    assign w_inrange = {1'b0, w_off} < Limit;

    assign instr_gnt_o = w_gnt_i;
    assign data_gnt_o  = w_gnt_d;

    assign mem_req_o   = w_gnt & w_inrange;
    assign mem_we_o    = mem_req_o & w_gnt_d & data_we_i;
    assign mem_be_o    = w_gnt_d ? data_be_i : 4'hF;
    assign mem_addr_o  = w_off[AW+1:2];
    assign mem_wdata_o = data_wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr_data <= 1'b1;
            r_rv_i     <= 1'b0;
            r_rv_d     <= 1'b0;
            r_err      <= 1'b0;
            r_rd       <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_ptr_data <= w_gnt_i;
            end
            r_rv_i <= w_gnt_i;
            r_rv_d <= w_gnt_d;
            r_err  <= w_gnt & ~w_inrange;
            r_rd   <= mem_req_o & ~mem_we_o;
        end
    end

    // Only an in-range read returns SRAM data; idle port stays at 0.
    assign instr_rvalid_o = r_rv_i;
    assign instr_err_o    = r_rv_i & r_err;
    assign instr_rdata_o  = (r_rv_i & r_rd) ? mem_rdata_i : 32'h0;
    assign data_rvalid_o  = r_rv_d;
    assign data_err_o     = r_rv_d & r_err;
    assign data_rdata_o   = (r_rv_d & r_rd) ? mem_rdata_i : 32'h0;

`ifdef CVE2_SRAM_ARBITER_STATS_EN
    logic [31:0] r_st_ig;
    logic [31:0] r_st_dg;
    logic [31:0] r_st_cf;
    logic [31:0] r_st_er;

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st_ig <= 32'h0;
            r_st_dg <= 32'h0;
            r_st_cf <= 32'h0;
            r_st_er <= 32'h0;
        end else begin
            r_st_ig <= sat_inc(r_st_ig, w_gnt_i);
            r_st_dg <= sat_inc(r_st_dg, w_gnt_d);
            r_st_cf <= sat_inc(r_st_cf, instr_req_i & data_req_i);
            r_st_er <= sat_inc(r_st_er, (r_rv_i | r_rv_d) & r_err);
        end
    end

    assign stat_instr_gnt_o = r_st_ig;
    assign stat_data_gnt_o  = r_st_dg;
    assign stat_conflict_o  = r_st_cf;
    assign stat_err_o       = r_st_er;
`endif

endmodule

// File: tb/tb_cve2_sram_arbiter.sv
// Directed bench for cve2_sram_arbiter with a behavioural 1-cycle SRAM.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_cve2_sram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i = 32'h0;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
`ifdef CVE2_SRAM_ARBITER_STATS_EN
    logic [31:0] stat_instr_gnt_o;
    logic [31:0] stat_data_gnt_o;
    logic [31:0] stat_conflict_o;
    logic [31:0] stat_err_o;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    cve2_sram_arbiter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
`ifdef CVE2_SRAM_ARBITER_STATS_EN
        .stat_instr_gnt_o (stat_instr_gnt_o),
        .stat_data_gnt_o  (stat_data_gnt_o),
        .stat_conflict_o  (stat_conflict_o),
        .stat_err_o       (stat_err_o),
`endif
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // SRAM model; reset reloads the two preset words used below.
    logic [31:0] sram [0:4095];
    always @(posedge clk_i) begin
        if (rst_i) begin
            sram[4] <= 32'hDEAD_BEEF;
            sram[8] <= 32'hAABB_CCDD;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b])
                        sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        rst_i       = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    logic [1:0] gseq [4];

    initial begin
        gseq[0] = 2'b01; gseq[1] = 2'b10;
        gseq[2] = 2'b01; gseq[3] = 2'b10;

        do_reset();
        // Idle after reset: {ignt,dgnt,irv,drv,ierr,derr,mreq}
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ctl", {25'h0, instr_gnt_o, data_gnt_o,
                instr_rvalid_o, data_rvalid_o, instr_err_o,
                data_err_o, mem_req_o}, 32'h0);
        end
        chk("idle_rdata", instr_rdata_o | data_rdata_o, 32'h0);

        // Single fetch of word 4
        @(negedge clk_i);
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
        #1;
        chk("fetch_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h2);
        chk("fetch_mem", {16'h0, 3'b0, mem_req_o, mem_we_o, mem_be_o,
            3'b0, 4'h0}, {16'h0, 3'b0, 1'b1, 1'b0, 4'hF, 3'b0, 4'h0});
        chk("fetch_addr", {20'h0, mem_addr_o}, 32'd4);
        @(negedge clk_i);
        instr_req_i = 1'b0;
        #1;
        chk("fetch_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h2);
        chk("fetch_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("fetch_err", {31'h0, instr_err_o}, 32'h0);

        // Partial write to word 8, then read it back
        @(negedge clk_i);
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
        data_addr_i = 32'h20; data_wdata_i = 32'h1234_5678;
        #1;
        chk("wr_gnt", {30'h0, instr_gnt_o, data_gnt_o}, 32'h1);
        chk("wr_mem", {26'h0, mem_req_o, mem_we_o, mem_be_o},
            {26'h0, 1'b1, 1'b1, 4'b0011});
        chk("wr_addr", {20'h0, mem_addr_o}, 32'd8);
        @(negedge clk_i);
        data_we_i = 1'b0; data_be_i = 4'hF;
        #1;
        chk("wr_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h1);
        chk("wr_rdata", data_rdata_o, 32'h0);
        chk("rd_gnt", {29'h0, data_gnt_o, mem_req_o, mem_we_o}, 32'h6);
        @(negedge clk_i);
        data_req_i = 1'b0;
        #1;
        chk("rd_rv", {31'h0, data_rvalid_o}, 32'h1);
        chk("rd_rdata", data_rdata_o, 32'hAABB_5678);

        // Out of range: first byte past the window, and a wrap-around address
        @(negedge clk_i);
        data_req_i = 1'b1; data_addr_i = 32'h0000_4000;
        #1;
        chk("oor_gnt", {30'h0, data_gnt_o, mem_req_o}, 32'h2);
        @(negedge clk_i);
        data_req_i = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'hFFFF_FFFC;
        #1;
        chk("oor_rv_err", {30'h0, data_rvalid_o, data_err_o}, 32'h3);
        chk("oor_rdata", data_rdata_o, 32'h0);
        chk("oor_i_gnt", {30'h0, instr_gnt_o, mem_req_o}, 32'h2);
        @(negedge clk_i);
        instr_req_i = 1'b0;
        #1;
        chk("oor_i_err", {29'h0, instr_rvalid_o, instr_err_o,
            data_err_o}, 32'h6);
        chk("oor_i_rdata", instr_rdata_o, 32'h0);

        // Contention from reset: data, instr, data, instr
        do_reset();
        @(negedge clk_i);
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_gnt%0d", i),
                {30'h0, instr_gnt_o, data_gnt_o}, {30'h0, gseq[i]});
            if (i > 0)
                chk($sformatf("cont_rv%0d", i),
                    {30'h0, instr_rvalid_o, data_rvalid_o},
                    {30'h0, gseq[i-1]});
            @(negedge clk_i);
        end
        instr_req_i = 1'b0; data_req_i = 1'b0;
        #1;
        chk("cont_rv_last", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h2);

        // Reset in the cycle after a grant discards the response
        @(negedge clk_i);
        data_req_i = 1'b1; data_addr_i = 32'h10;
        #1;
        chk("rst_mid_gnt", {31'h0, data_gnt_o}, 32'h1);
        @(negedge clk_i);
        data_req_i = 1'b0; rst_i = 1'b1;
        #1;
        chk("rst_mid_rv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_rv", {30'h0, instr_rvalid_o, data_rvalid_o},
                32'h0);
        end
`ifdef CVE2_SRAM_ARBITER_STATS_EN
        chk("stat_ig", stat_instr_gnt_o, 32'h0);
        chk("stat_dg", stat_data_gnt_o, 32'h0);
        chk("stat_cf", stat_conflict_o, 32'h0);
        chk("stat_er", stat_err_o, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cve2_sram_arbiter.md
Name: cve2_sram_arbiter

Overview:
- Memory-side neighbour of the core top: consumes the core's instruction-fetch and data req/gnt/rvalid interfaces and serves both from one single-port synchronous SRAM with 1-cycle read latency.
- Round-robin arbitration between the two masters.
- Same-cycle grant, fixed 1-cycle response.
- Bus error for addresses outside the SRAM window.
- Used in standalone core testbenches and small SoC tiles.

Parameters:
- MemWords, 4096, SRAM depth in 32-bit words; power of two, >= 2; index width AW = $clog2(MemWords).
- BaseAddr, 32'h0000_0000, byte base address of the SRAM window; aligned to MemWords*4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_addr_i  in  32  fetch byte address
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error; qualified by instr_rvalid_o
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_rdata_o  out  32  read data
- data_err_o  out  1  data bus error; qualified by data_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte mask
- mem_addr_o  out  AW  SRAM word index
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data; valid the cycle after mem_req_o

Behaviour:
- The block has one clock (clk_i). Reset rst_i is asynchronous and active-high.
- Reset values:
  - All gnt/rvalid/err outputs 0; rdata outputs 0.
  - mem_req_o = 0.
  - Priority pointer = data.
  - Response-pending register empty.
- Arbitration is combinational each cycle:
  - One requester: it is granted.
  - Both requesting: the master opposite the last granted one wins. The pointer updates on every grant.
  - At most one gnt per cycle. The loser keeps req high and is granted in a later cycle.
  - Grant is never withheld when exactly one master requests.
- In-range check: (addr - BaseAddr) < MemWords*4, evaluated on the full 32 bits with unsigned wrap.
  - Index = (addr - BaseAddr)[AW+1:2]. addr[1:0] is ignored.
- On a granted in-range access:
  - mem_req_o = 1. mem_we_o = data_we_i for data, 0 for instr. mem_be_o = data_be_i for data, 4'hF for instr.
  - mem_addr_o = index. mem_wdata_o = data_wdata_i.
- On a granted out-of-range access:
  - mem_req_o = 0; no SRAM access.
  - Response is flagged as an error.
- Response timing:
  - Exactly one cycle after a grant, rvalid is asserted for one cycle on the granted port only.
  - rdata = mem_rdata_i for an in-range read; 0 for writes and errors.
  - err = 1 only for out-of-range accesses.
  - The non-responding port's rdata/err are held at 0.
- Back-to-back grants every cycle are allowed; throughput is 1 access/cycle. There is no response back-pressure.
- Simultaneous events: a grant and a response in the same cycle on different or the same ports is legal and independent.
- Reset asserted mid-operation: the pending response is discarded and no rvalid is issued after reset release.
- Requests withdrawn without a grant are not served. No state is kept.

Optional Feature:
- Macro CVE2_SRAM_ARBITER_STATS_EN.
- When defined, the block adds four outputs, each 32 bits, saturating at 32'hFFFF_FFFF, reset to 0:
  - stat_instr_gnt_o: count of instr grants.
  - stat_data_gnt_o: count of data grants.
  - stat_conflict_o: cycles with both reqs high.
  - stat_err_o: count of error responses issued.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_i pulse with reqs low -> all outputs 0, mem_req_o 0 for 10 cycles.
- Single fetch: instr_req_i=1, addr 32'h0000_0010, SRAM word 4 = 32'hDEAD_BEEF -> instr_gnt_o same cycle, mem_addr_o=4, next cycle instr_rvalid_o=1, instr_rdata_o=32'hDEAD_BEEF, instr_err_o=0.
- Write then read: data write addr 32'h20, be 4'b0011, wdata 32'h1234_5678 -> mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=8, data_rvalid_o next cycle with rdata 0. Subsequent read of the same address returns 32'hxxxx_5678 per the SRAM model.
- Contention: both reqs held high for 4 cycles after reset -> grants alternate data, instr, data, instr; each rvalid follows on the matching port one cycle later.
- Out of range: data read addr BaseAddr+MemWords*4 (32'h0000_4000 with defaults) -> data_gnt_o=1, mem_req_o=0, next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
- Reset mid-access: assert rst_i in the cycle after a grant -> no rvalid observed after release. With CVE2_SRAM_ARBITER_STATS_EN, all stat outputs read 0.
